// File: rtl/spi_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | spi_pkg : shared SPI types and constants (state encoding, default width) |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
package spi_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RX   = 2'd1
    } spi_rx_state_t;

    localparam int SPI_DEFAULT_WIDTH = 8;

endpackage
`default_nettype wire

// File: rtl/spi_sync.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | spi_sync : 1-bit multi-flop synchronizer with configurable reset value   |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module spi_sync #(
    parameter int   SYNC_STAGES = 2,
    parameter logic RESET_VAL   = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [SYNC_STAGES-1:0] r_sync;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync <= {SYNC_STAGES{RESET_VAL}};
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], d};
        end
    end

    assign q = r_sync[SYNC_STAGES-1];

endmodule
`default_nettype wire

// File: rtl/spi_slave_rx.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | spi_slave_rx : SPI mode-0 slave receiver, oversampled, valid/ready out.  |
// | Optional full-duplex transmit path enabled by macro SPI_SLAVE_MISO_EN.   |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module spi_slave_rx
    import spi_pkg::*;
#(
    parameter int DATA_WIDTH  = SPI_DEFAULT_WIDTH,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  sclk,
    input  logic                  cs,
    input  logic                  mosi,
    output logic [DATA_WIDTH-1:0] rx_data,
    output logic                  rx_valid,
    input  logic                  rx_ready,
    output logic                  overrun,
    output logic                  frame_err,
    output logic                  busy
`ifdef SPI_SLAVE_MISO_EN
    ,
    input  logic [DATA_WIDTH-1:0] tx_data,
    output logic                  miso
`endif
);

    localparam int                CNT_W   = $clog2(DATA_WIDTH + 1);
    localparam int                FLUSH_W = $clog2(SYNC_STAGES + 1);
    localparam logic [CNT_W-1:0]  c_last  = CNT_W'(DATA_WIDTH - 1);
    localparam logic [FLUSH_W-1:0] c_flush_done = FLUSH_W'(SYNC_STAGES);

    logic w_sclk_s, w_cs_s, w_mosi_s;

    spi_sync #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sclk (
        .clk(clk), .rst(rst), .d(sclk), .q(w_sclk_s)
    );
    spi_sync #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_cs (
        .clk(clk), .rst(rst), .d(cs), .q(w_cs_s)
    );
    spi_sync #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_mosi (
        .clk(clk), .rst(rst), .d(mosi), .q(w_mosi_s)
    );

    spi_rx_state_t         r_state;
    logic                  r_sclk_prev;
    logic [CNT_W-1:0]      r_cnt;
    logic [DATA_WIDTH-1:0] r_shift;
    logic [DATA_WIDTH-1:0] r_rx_data;
    logic                  r_rx_valid;
    logic                  r_overrun;
    logic                  r_frame_err;
    logic                  r_busy;
    logic [FLUSH_W-1:0]    r_flush;
    logic                  r_armed;

    logic                  w_rise;
    logic                  w_start;
    logic                  w_complete;
    logic [DATA_WIDTH-1:0] w_shift_next;

    assign w_rise       = w_sclk_s & ~r_sclk_prev;
    assign w_start      = (r_state == IDLE) && r_armed && !w_cs_s;
    assign w_complete   = (r_state == RX) && w_rise && (r_cnt == c_last);
    assign w_shift_next = {r_shift[DATA_WIDTH-2:0], w_mosi_s};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sclk_prev <= 1'b0;
        end else begin
            r_sclk_prev <= w_sclk_s;
        end
    end

    // After reset the cs synchronizer shows its reset value, not the pin; a frame
    // may only start once the real pin has been seen high (r_armed).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_flush <= '0;
            r_armed <= 1'b0;
        end else if (r_flush != c_flush_done) begin
            r_flush <= r_flush + 1'b1;
        end else if (w_cs_s) begin
            r_armed <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_shift     <= '0;
            r_rx_data   <= '0;
            r_rx_valid  <= 1'b0;
            r_overrun   <= 1'b0;
            r_frame_err <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_overrun   <= 1'b0;
            r_frame_err <= 1'b0;
            if (r_rx_valid && rx_ready) begin
                r_rx_valid <= 1'b0;
            end
            case (r_state)
                IDLE: begin
                    r_cnt   <= '0;
                    r_shift <= '0;
                    if (w_start) begin
                        r_state <= RX;
                        r_busy  <= 1'b1;
                    end
                end
                RX: begin
                    if (w_rise) begin
                        r_shift <= w_shift_next;
                        if (w_complete) begin
                            r_rx_data  <= w_shift_next;
                            r_rx_valid <= 1'b1;
                            r_overrun  <= r_rx_valid && !rx_ready;
                            r_cnt      <= '0;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                    // A word finishing on the same edge as cs rising wins over frame_err.
                    if (w_cs_s) begin
                        r_state     <= IDLE;
                        r_busy      <= 1'b0;
                        r_frame_err <= (r_cnt != '0) && !w_complete;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

`ifdef SPI_SLAVE_MISO_EN
    logic                  w_fall;
    logic [DATA_WIDTH-1:0] r_tx;

    assign w_fall = ~w_sclk_s & r_sclk_prev;

    // No shift on the fall after a word completes: r_cnt is 0 and the fresh
    // word's MSB must stay on miso for the next rise.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tx <= '0;
        end else if (w_start || w_complete) begin
            r_tx <= tx_data;
        end else if (r_state == RX && !w_cs_s) begin
            if (w_fall && r_cnt != '0) begin
                r_tx <= {r_tx[DATA_WIDTH-2:0], 1'b0};
            end
        end else begin
            r_tx <= '0;
        end
    end

    assign miso = r_tx[DATA_WIDTH-1];
`endif

    assign rx_data   = r_rx_data;
    assign rx_valid  = r_rx_valid;
    assign overrun   = r_overrun;
    assign frame_err = r_frame_err;
    assign busy      = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_spi_slave_rx.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_spi_slave_rx : directed bench with a bit-queue reference model         |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_spi_slave_rx;

    localparam int W = 8;
    localparam int S = 2;

    logic         clk = 1'b0;
    logic         rst, sclk, cs, mosi, rx_ready;
    logic [W-1:0] rx_data;
    logic         rx_valid, overrun, frame_err, busy;
`ifdef SPI_SLAVE_MISO_EN
    logic [W-1:0] tx_data = 8'hE7;
    logic         miso;
    logic [W-1:0] miso_word = '0;
`endif

    always #5 clk = ~clk;

    spi_slave_rx #(.DATA_WIDTH(W), .SYNC_STAGES(S)) dut (
        .clk(clk), .rst(rst), .sclk(sclk), .cs(cs), .mosi(mosi),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .overrun(overrun), .frame_err(frame_err), .busy(busy)
`ifdef SPI_SLAVE_MISO_EN
        , .tx_data(tx_data), .miso(miso)
`endif
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Reference model: raw pins delayed by the synchronizer depth, bits
    // collected in a queue and packed MSB first when W have arrived.
    logic         p_sclk [S+2];
    logic         p_cs   [S+2];
    logic         p_mosi [S+2];
    logic         p_v    [S+2];
    logic         bits[$];
    logic         m_valid, m_busy, m_ov, m_fe, m_in, m_armed;
    logic [W-1:0] m_data;

    initial forever begin
        @(posedge clk or posedge rst);
        if (rst) begin
            for (int i = 0; i < S + 2; i++) begin
                p_sclk[i] = 1'b0; p_cs[i] = 1'b1; p_mosi[i] = 1'b0; p_v[i] = 1'b0;
            end
            bits.delete();
            m_valid = 0; m_busy = 0; m_ov = 0; m_fe = 0; m_in = 0; m_armed = 0;
            m_data = '0;
        end else begin
            logic ds, dm, dv, rise, old_valid, done;
            int   pre;
            for (int i = S + 1; i > 0; i--) begin
                p_sclk[i] = p_sclk[i-1]; p_cs[i] = p_cs[i-1];
                p_mosi[i] = p_mosi[i-1]; p_v[i] = p_v[i-1];
            end
            p_sclk[0] = sclk; p_cs[0] = cs; p_mosi[0] = mosi; p_v[0] = 1'b1;
            ds   = p_cs[S];
            dm   = p_mosi[S];
            dv   = p_v[S];
            rise = p_sclk[S] & ~p_sclk[S+1];
            old_valid = m_valid;
            m_ov = 0; m_fe = 0;
            if (m_valid && rx_ready) m_valid = 0;
            if (!m_in) begin
                bits.delete();
                if (m_armed && !ds) m_in = 1;
            end else begin
                done = 0;
                pre  = bits.size();
                if (rise) begin
                    bits.push_back(dm);
                    if (bits.size() == W) begin
                        m_data = '0;
                        foreach (bits[i]) m_data = {m_data[W-2:0], bits[i]};
                        m_ov    = old_valid && !rx_ready;
                        m_valid = 1;
                        bits.delete();
                        done = 1;
                    end
                end
                if (ds) begin
                    m_in = 0;
                    m_fe = (pre != 0) && !done;
                end
            end
            if (dv && ds) m_armed = 1;
            m_busy = m_in;
        end
    end

    logic [W-1:0] acc[$];
    int           fe_cnt = 0;
    int           ov_cnt = 0;

    initial forever begin
        @(posedge clk);
        #1;
        if (rst) begin
            check("reset_rx_data",   rx_data,   0);
            check("reset_rx_valid",  rx_valid,  0);
            check("reset_overrun",   overrun,   0);
            check("reset_frame_err", frame_err, 0);
            check("reset_busy",      busy,      0);
        end else begin
            check("rx_valid",  rx_valid,  m_valid);
            check("rx_data",   rx_data,   m_data);
            check("busy",      busy,      m_busy);
            check("overrun",   overrun,   m_ov);
            check("frame_err", frame_err, m_fe);
            if (rx_valid && rx_ready) acc.push_back(rx_data);
            fe_cnt += int'(frame_err);
            ov_cnt += int'(overrun);
        end
    end

    function automatic logic [31:0] acc_at(input int i);
        return (i < acc.size()) ? 32'(acc[i]) : 32'hDEAD;
    endfunction

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send(input logic [W-1:0] w, input int nb);
        for (int i = 0; i < nb; i++) begin
            mosi = w[W-1-i];
            idle(4);
            sclk = 1'b1;
`ifdef SPI_SLAVE_MISO_EN
            miso_word = {miso_word[W-2:0], miso};
`endif
            idle(4);
            sclk = 1'b0;
        end
    endtask

    task automatic clear_log();
        acc.delete();
        fe_cnt = 0;
        ov_cnt = 0;
    endtask

    task automatic frame(input logic [W-1:0] w);
        cs = 1'b0; idle(4);
        send(w, W);
        idle(4); cs = 1'b1; idle(12);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; sclk = 1'b0; cs = 1'b1; mosi = 1'b0; rx_ready = 1'b1;
        idle(3);
        rst = 1'b0;
        idle(10);

        clear_log();
        frame(8'hAA);
        check("t1_count", acc.size(), 1);
        check("t1_word", acc_at(0), 32'hAA);
        check("t1_fe", fe_cnt, 0);
        check("t1_ov", ov_cnt, 0);

        clear_log();
        cs = 1'b0; idle(4);
        send(8'h3C, W);
        send(8'hC3, W);
        idle(4); cs = 1'b1; idle(12);
        check("t2_count", acc.size(), 2);
        check("t2_word0", acc_at(0), 32'h3C);
        check("t2_word1", acc_at(1), 32'hC3);

        clear_log();
        rx_ready = 1'b0;
        cs = 1'b0; idle(4);
        send(8'h3C, W);
        send(8'hC3, W);
        idle(4); cs = 1'b1; idle(20);
        check("t3_ov", ov_cnt, 1);
        check("t3_data", rx_data, 32'hC3);
        check("t3_valid_held", rx_valid, 1);
        rx_ready = 1'b1;
        @(posedge clk); #1;
        check("t3_valid_cleared", rx_valid, 0);
        idle(4);

        clear_log();
        cs = 1'b0; idle(4);
        send(8'hFF, 5);
        idle(4); cs = 1'b1; idle(12);
        check("t4_fe", fe_cnt, 1);
        check("t4_no_word", acc.size(), 0);
        frame(8'h81);
        check("t4_word", acc_at(0), 32'h81);

        clear_log();
        cs = 1'b0; idle(4);
        send(8'h5A, 4);
        rst = 1'b1; idle(3); rst = 1'b0;
        send(8'hA0, 4);
        idle(4); cs = 1'b1; idle(12);
        check("t5_ignored", acc.size(), 0);
        frame(8'h5A);
        check("t5_word", acc_at(0), 32'h5A);
        check("t5_data", rx_data, 32'h5A);
        check("t5_fe", fe_cnt, 0);

`ifdef SPI_SLAVE_MISO_EN
        clear_log();
        frame(8'h00);
        check("t6_miso", miso_word, 32'hE7);
        check("t6_word", acc_at(0), 32'h00);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
